// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared op codes and FSM encoding for the register bank
package reg_bank_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LD  = 3'd1,
        OP_SET = 3'd2,
        OP_CLR = 3'd3,
        OP_SHL = 3'd4,
        OP_SHR = 3'd5,
        OP_INC = 3'd6,
        OP_DEC = 3'd7
    } op_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/reg_bank_alu.sv
// rtl/reg_bank_alu.sv - combinational next-value function for one shadow register
module reg_bank_alu
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] next
);

    always_comb begin
        next = cur;
        unique case (op)
            OP_NOP: next = cur;
            OP_LD:  next = wr_data;
            OP_SET: next = '1;
            OP_CLR: next = '0;
            OP_SHL: next = {cur[WIDTH-2:0], wr_data[0]};
            OP_SHR: next = {wr_data[0], cur[WIDTH-1:1]};
            OP_INC: next = cur + WIDTH'(1);
            OP_DEC: next = cur - WIDTH'(1);
            default: next = cur;
        endcase
    end

endmodule

// File: rtl/reg_bank_ctl.sv
// rtl/reg_bank_ctl.sv - shadow/live register bank with atomic commit and init sweep
module reg_bank_ctl
    import reg_bank_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] INIT_VAL = '0,
    localparam int              CH_W     = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [CH_W-1:0]     wr_chan,
    input  logic [2:0]          wr_op,
    input  logic [WIDTH-1:0]    wr_data,
    input  logic                commit,
    input  logic                sweep_req,
    output logic                busy,
    output logic [CHANNELS-1:0] dirty,
    input  logic [CH_W-1:0]     rd_chan,
    input  logic                out_en,
    output logic [WIDTH-1:0]    rd_data,
    output logic [WIDTH-1:0]    rd_data_n
);

    localparam logic [CH_W:0] NCH = CHANNELS[CH_W:0];

    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    live   [CHANNELS];
    logic [CH_W-1:0]     idx;
    state_t              state;
    logic [WIDTH-1:0]    alu_cur;
    logic [WIDTH-1:0]    alu_next;
    logic                wr_fire;
    logic [CHANNELS-1:0] dirty_next;
    logic [WIDTH-1:0]    rd_sel;

    // Out-of-range channels still handshake but must never touch state.
    assign wr_fire = wr_valid && wr_ready && ({1'b0, wr_chan} < NCH);
    assign alu_cur = ({1'b0, wr_chan} < NCH) ? shadow[wr_chan] : INIT_VAL;

    reg_bank_alu #(.WIDTH(WIDTH)) u_alu (
        .op      (op_t'(wr_op)),
        .cur     (alu_cur),
        .wr_data (wr_data),
        .next    (alu_next)
    );

    // Commit clears first so a same-cycle write leaves its channel dirty.
    always_comb begin
        dirty_next = commit ? '0 : dirty;
        if (wr_fire && op_t'(wr_op) != OP_NOP)
            dirty_next[wr_chan] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= INIT_VAL;
                live[i]   <= INIT_VAL;
            end
            dirty    <= '0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
            idx      <= '0;
            state    <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (sweep_req) begin
                        state    <= SWEEP;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                        idx      <= '0;
                    end else begin
                        if (commit) begin
                            for (int i = 0; i < CHANNELS; i++)
                                if (dirty[i]) live[i] <= shadow[i];
                        end
                        if (wr_fire)
                            shadow[wr_chan] <= alu_next;
                        dirty <= dirty_next;
                    end
                end
                SWEEP: begin
                    shadow[idx] <= INIT_VAL;
                    if ({1'b0, idx} == NCH - 1'b1) begin
                        for (int i = 0; i < CHANNELS; i++)
                            live[i] <= INIT_VAL;
                        dirty    <= '0;
                        busy     <= 1'b0;
                        wr_ready <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rd_sel    = ({1'b0, rd_chan} < NCH) ? live[rd_chan] : INIT_VAL;
    assign rd_data   = out_en ? rd_sel  : '0;
    assign rd_data_n = out_en ? ~rd_sel : '0;

endmodule
